// File: rtl/frontend_pkg.sv
// Shared front-end types: instruction width, bubble encoding and queue entry.
package frontend_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP_WORD = 32'd0;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/inst_ring.sv
// Circular instruction storage: two write ports at tail/tail+1, two
// asynchronous read ports at head/head+1. Pointer management lives in the
// owner; this block only holds data.
module inst_ring
  import frontend_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en0,
  input  logic            wr_en1,
  input  logic [PW-1:0]   wr_ptr,
  input  fq_entry_t       wr_data0,
  input  fq_entry_t       wr_data1,
  input  logic [PW-1:0]   rd_ptr,
  output fq_entry_t       rd_data0,
  output fq_entry_t       rd_data1
);

  fq_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr1;
  logic [PW-1:0]   rd_ptr1;

  assign wr_ptr1 = wr_ptr + PW'(1);
  assign rd_ptr1 = rd_ptr + PW'(1);

  // Store up to two entries per cycle; storage is not reset (data is
  // don't-care while the matching valid is low).
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wr_ptr]  <= wr_data0;
    if (wr_en1) mem[wr_ptr1] <= wr_data1;
  end

  // Asynchronous read of head and head+1.
  always_comb begin
    rd_data0 = mem[rd_ptr];
    rd_data1 = mem[rd_ptr1];
  end

endmodule

// File: rtl/fetch_queue.sv
// Front-end sequencer and instruction buffer: drives the fetch PC, filters
// zero words out of the returned pair, queues survivors with their PCs,
// hands up to two per cycle to decode, and detects end of program.
module fetch_queue
  import frontend_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ZERO_LIMIT = 10,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out,
  input  logic [31:0] inst1_in,
  input  logic [31:0] inst2_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid1,
  output logic        out_valid2,
  output logic [31:0] out_inst1,
  output logic [31:0] out_inst2,
  output logic [31:0] out_pc1,
  output logic [31:0] out_pc2,
  input  logic [1:0]  dec_take,
  output logic        done
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned ZW = $clog2(ZERO_LIMIT + 1);

  logic          resp_valid;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [ZW-1:0] zero_run;
  logic          stop;

  logic          redirect_go;
  logic          live;
  logic [31:0]   fill_need;
  logic          keep1;
  logic          keep2;
  logic [1:0]    enq_n;
  logic [1:0]    take_c;
  logic [1:0]    pop_n;
  logic [ZW-1:0] z_mid;
  logic [ZW-1:0] zero_run_next;
  logic          stop_next;
  logic          done_set;

  logic          wr_en0;
  logic          wr_en1;
  fq_entry_t     wr_data0;
  fq_entry_t     wr_data1;
  fq_entry_t     rd_data0;
  fq_entry_t     rd_data1;

  function automatic logic [ZW-1:0] sat_inc(input logic [ZW-1:0] z);
    return (z >= ZW'(ZERO_LIMIT)) ? z : z + ZW'(1);
  endfunction

  // Issue decision, response filtering, pop sizing and zero-run tracking.
  always_comb begin
    redirect_go = redirect_valid && !done;
    fill_need   = 32'(count) + (resp_valid ? 32'd4 : 32'd2);
    live        = !done && !stop && (fill_need <= 32'(DEPTH));

    keep1 = resp_valid && (inst1_in != NOP_WORD);
    keep2 = resp_valid && (inst2_in != NOP_WORD);
    enq_n = {1'b0, keep1} + {1'b0, keep2};

    // A lone surviving second word goes to the tail slot, keeping the
    // queue dense.
    wr_en0        = !redirect_go && (keep1 || keep2);
    wr_en1        = !redirect_go && keep1 && keep2;
    wr_data0.pc   = keep1 ? resp_pc : resp_pc + 32'd4;
    wr_data0.inst = keep1 ? inst1_in : inst2_in;
    wr_data1.pc   = resp_pc + 32'd4;
    wr_data1.inst = inst2_in;

    take_c = (dec_take > 2'd2) ? 2'd2 : dec_take;
    if (count == '0)
      pop_n = 2'd0;
    else if (count == CW'(1))
      pop_n = (take_c == 2'd0) ? 2'd0 : 2'd1;
    else
      pop_n = take_c;

    z_mid         = (inst1_in != NOP_WORD) ? '0 : sat_inc(zero_run);
    zero_run_next = zero_run;
    if (resp_valid)
      zero_run_next = (inst2_in != NOP_WORD) ? '0 : sat_inc(z_mid);
    stop_next = stop || (zero_run_next == ZW'(ZERO_LIMIT));
    done_set  = stop && (count == '0) && !resp_valid;
  end

  // Sequencer and queue bookkeeping; reset beats redirect beats normal flow.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out     <= RESET_PC;
      resp_valid <= 1'b0;
      resp_pc    <= '0;
      count      <= '0;
      head       <= '0;
      tail       <= '0;
      zero_run   <= '0;
      stop       <= 1'b0;
      done       <= 1'b0;
    end else if (redirect_go) begin
      pc_out     <= redirect_pc;
      resp_valid <= 1'b0;
      count      <= '0;
      head       <= '0;
      tail       <= '0;
      zero_run   <= '0;
      stop       <= 1'b0;
    end else begin
      resp_valid <= live;
      if (live) begin
        resp_pc <= pc_out;
        pc_out  <= pc_out + 32'd8;
      end
      count    <= count - CW'(pop_n) + CW'(enq_n);
      head     <= head + PW'(pop_n);
      tail     <= tail + PW'(enq_n);
      zero_run <= zero_run_next;
      stop     <= stop_next;
      done     <= done || done_set;
    end
  end

  inst_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk      (clk),
    .wr_en0   (wr_en0),
    .wr_en1   (wr_en1),
    .wr_ptr   (tail),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .rd_ptr   (head),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1)
  );

  // Decode-facing view of head and head+1.
  always_comb begin
    out_valid1 = (count != '0);
    out_valid2 = (count > CW'(1));
    out_inst1  = rd_data0.inst;
    out_pc1    = rd_data0.pc;
    out_inst2  = rd_data1.inst;
    out_pc2    = rd_data1.pc;
  end

endmodule
